// File: rtl/imm_sequencer.sv
// Immediate extension sequencer: 13-bit raw immediate -> 16-bit ALU B operand, one-entry output buffer.
// Define IMMSEQ_PREFIX_EN to build the PREFIX mode and the ARMED prefix state.
module imm_sequencer #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_prefixed,
    output logic             armed
);
    localparam int P = OUT_W - IN_W;
    localparam logic [1:0] MODE_ZEXT  = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic             out_valid_reg;
    logic             out_prefixed_reg;
    logic [OUT_W-1:0] out_imm_reg;
    logic [OUT_W-1:0] result_next;
    logic             prefixed_next;
    logic [P-1:0]     upper_next;
    logic [P-1:0]     prefix_bits;
    logic             accept;
    logic             produce;
    logic             armed_int;

    assign in_ready = !flush && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef IMMSEQ_PREFIX_EN
    localparam logic [1:0] MODE_PREFIX = 2'b10;

    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;
    state_t       state_reg;
    state_t       state_next;
    logic [P-1:0] prefix_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // SHIFT neither uses nor consumes an armed prefix.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else if (accept) begin
            case (in_mode)
                MODE_PREFIX: state_next = ARMED;
                MODE_SHIFT:  state_next = state_reg;
                default:     state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        armed_int = (state_reg == ARMED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefix_reg <= '0;
        end else if (flush) begin
            prefix_reg <= '0;
        end else if (accept && (in_mode == MODE_PREFIX)) begin
            prefix_reg <= in_imm[P-1:0];
        end
    end

    assign prefix_bits = prefix_reg;
    assign produce     = (in_mode != MODE_PREFIX);
`else
    // Without the prefix feature mode 10 falls through to sign extension.
    assign armed_int   = 1'b0;
    assign prefix_bits = '0;
    assign produce     = 1'b1;
`endif

    // An armed prefix overrides the SEXT/ZEXT choice for the upper bits.
    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_upper
            assign upper_next[gi] = armed_int ? prefix_bits[gi]
                                              : ((in_mode != MODE_ZEXT) & in_imm[IN_W-1]);
        end
    endgenerate

    always_comb begin
        result_next   = {upper_next, in_imm};
        prefixed_next = armed_int;
        if (in_mode == MODE_SHIFT) begin
            result_next   = {in_imm[OUT_W-P-1:0], {P{1'b0}}};
            prefixed_next = 1'b0;
        end
    end

    // A drain with no new result empties the buffer; accept implies the slot is free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg    <= 1'b0;
            out_imm_reg      <= '0;
            out_prefixed_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg    <= 1'b0;
            out_prefixed_reg <= 1'b0;
        end else if (accept && produce) begin
            out_valid_reg    <= 1'b1;
            out_imm_reg      <= result_next;
            out_prefixed_reg <= prefixed_next;
        end else if (out_ready) begin
            out_valid_reg    <= 1'b0;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_imm      = out_imm_reg;
    assign out_prefixed = out_prefixed_reg;
    assign armed        = armed_int;

endmodule

// File: tb/tb_imm_sequencer.sv
// Self-checking bench for imm_sequencer: directed test-plan cases plus random traffic against an arithmetic model.
// Honours IMMSEQ_PREFIX_EN the same way as the design.
module tb_imm_sequencer;
`ifdef IMMSEQ_PREFIX_EN
    localparam bit PREFIX_EN = 1'b1;
`else
    localparam bit PREFIX_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic        out_prefixed;
    logic        armed;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid;
    int          m_imm;
    bit          m_prefixed;
    bit          m_armed;
    int          m_pre;
    bit          m_cleared;

    imm_sequencer #(.IN_W(13), .OUT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_prefixed (out_prefixed),
        .armed        (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Extended value from the mode rules, as plain integer arithmetic.
    function automatic int ref_result(input int mode, input int imm, input bit arm, input int pre);
        if (mode == 3) return (imm * 8) % 65536;
        if (arm) return pre * 8192 + imm;
        if (mode == 1) return imm;
        return (imm >= 4096) ? imm + 57344 : imm;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_imm = 0; m_prefixed = 0; m_armed = 0; m_pre = 0; m_cleared = 1;
    endtask

    task automatic step(input logic v, input logic [1:0] m, input logic [12:0] imm,
                        input logic ordy, input logic fl);
        bit exp_ready;
        bit acc;
        int r;
        @(negedge clk);
        in_valid = v; in_mode = m; in_imm = imm; out_ready = ordy; flush = fl;
        #1;
        exp_ready = !fl && (!m_valid || ordy);
        check("in_ready", in_ready, exp_ready);
        acc = v && exp_ready;
        r = ref_result(int'(m), int'(imm), m_armed, m_pre);
        if (acc) $display("accept mode=%0d imm=%h armed=%0d", m, imm, m_armed);
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_prefixed = 0; m_armed = 0; m_pre = 0; m_cleared = 1;
        end else begin
            m_cleared = 0;
            if (acc && (!PREFIX_EN || m != 2'b10)) begin
                m_valid = 1; m_imm = r; m_prefixed = m_armed && (m != 2'b11);
            end else if (ordy) begin
                m_valid = 0;
            end
            if (acc && PREFIX_EN) begin
                if (m == 2'b10) begin
                    m_armed = 1; m_pre = int'(imm) % 8;
                end else if (m != 2'b11) begin
                    m_armed = 0;
                end
            end
        end
        #1;
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_imm", out_imm, m_imm);
            check("out_prefixed", out_prefixed, m_prefixed);
        end
        if (m_cleared) check("out_prefixed_clr", out_prefixed, 0);
        check("armed", armed, m_armed);
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_imm = '0; in_mode = '0; out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_imm", out_imm, 16'h0000);
        check("rst_out_prefixed", out_prefixed, 0);
        check("rst_armed", armed, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic extension modes
        step(1, 2'b00, 13'h1000, 1, 0);
        check("sext_1000", out_imm, 16'hF000);
        step(1, 2'b01, 13'h1000, 1, 0);
        check("zext_1000", out_imm, 16'h1000);
        step(1, 2'b11, 13'h0001, 1, 0);
        check("shift_0001", out_imm, 16'h0008);
        step(1, 2'b11, 13'h1FFF, 1, 0);
        check("shift_1fff", out_imm, 16'hFFF8);
        step(0, 2'b00, 13'h0000, 1, 0);

`ifdef IMMSEQ_PREFIX_EN
        step(1, 2'b10, 13'h0005, 1, 0);
        check("prefix_armed", armed, 1);
        check("prefix_no_out", out_valid, 0);
        step(1, 2'b00, 13'h0001, 1, 0);
        check("prefixed_val", out_imm, 16'hA001);
        check("prefixed_flag", out_prefixed, 1);
        check("prefix_consumed", armed, 0);
`else
        step(1, 2'b10, 13'h1000, 1, 0);
        check("mode10_sext", out_imm, 16'hF000);
        check("mode10_unarmed", armed, 0);
`endif

        // Backpressure: the first result holds while the second waits
        step(0, 2'b00, 13'h0000, 1, 0);
        step(1, 2'b00, 13'h0002, 0, 0);
        step(1, 2'b00, 13'h0003, 0, 0);
        check("bp_hold", out_imm, 16'h0002);
        step(1, 2'b00, 13'h0003, 1, 0);
        check("bp_next", out_imm, 16'h0003);
        step(0, 2'b00, 13'h0000, 1, 0);

        // Flush with armed prefix, full buffer and a pending request
        if (PREFIX_EN) step(1, 2'b10, 13'h0006, 1, 0);
        step(1, 2'b11, 13'h0004, 0, 0);
        step(1, 2'b00, 13'h0007, 1, 1);
        check("flush_valid", out_valid, 0);
        check("flush_armed", armed, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 13'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset mid-stream, checked before any clock edge
        step(1, 2'b00, 13'h1234, 0, 0);
        @(posedge clk);
        #2 reset = 1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_imm", out_imm, 16'h0000);
        check("arst_out_prefixed", out_prefixed, 0);
        check("arst_armed", armed, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        step(1, 2'b01, 13'h0ABC, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_sequencer.md
# imm_sequencer

Sequencing controller for the 13-to-16-bit immediate extension path in the 16-bit datapath. It sits between instruction decode and the ALU B-operand mux. It accepts one immediate request per handshake and selects the extension mode. It can hold a prefix that supplies the upper bits of the next immediate. It delivers a registered 16-bit operand through a one-entry output buffer with backpressure.

## Interface
- IN_W, 13, width of the raw immediate field
- OUT_W, 16, width of the extended operand; prefix width P = OUT_W-IN_W (3)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- flush  input  1  synchronous; drops the buffered output and the armed prefix
- in_valid  input  1  request present
- in_ready  output  1  request accepted this cycle when in_valid && in_ready
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  00 SEXT, 01 ZEXT, 10 PREFIX, 11 SHIFT
- out_valid  output  1  out_imm holds a result
- out_ready  input  1  consumer takes the result when out_valid && out_ready
- out_imm  output  OUT_W  extended immediate
- out_prefixed  output  1  result was built from an armed prefix
- armed  output  1  prefix currently held

## Operation
- Prefix FSM states:
  - IDLE to ARMED on an accepted PREFIX.
  - ARMED to IDLE on an accepted SEXT or ZEXT, or on flush.
  - ARMED to ARMED on an accepted PREFIX; the new prefix overwrites the old one.
  - ARMED to ARMED on an accepted SHIFT; the prefix is neither used nor consumed.
- PREFIX: latches in_imm[P-1:0] into the prefix register. Produces no output. out_valid is unaffected.
- SEXT in IDLE: {P{in_imm[IN_W-1]}, in_imm}.
- ZEXT in IDLE: {P'b0, in_imm}.
- SEXT or ZEXT in ARMED: {prefix, in_imm}, with out_prefixed=1. The mode only selects the upper bits when no prefix is armed.
- SHIFT: {in_imm[OUT_W-P-1:0], P'b0}, i.e. in_imm shifted left by P and truncated to OUT_W. out_prefixed=0.
- Output buffer: one entry.
  - in_ready = !flush && (!out_valid || out_ready). This gives full throughput under continuous out_ready.
  - PREFIX requests also obey in_ready. This keeps accept ordering simple.
- flush:
  - Clears out_valid, out_prefixed and the prefix FSM.
  - Forces in_ready=0 that cycle. flush wins over a simultaneous in_valid or out_ready.
- All arithmetic is pure bit concatenation. There is no overflow condition.

## Timing
- Reset values: out_valid=0, out_imm=16'h0000, out_prefixed=0, armed=0, prefix register=0, state IDLE. in_ready=1 after reset deasserts.
- Latency: a result accepted in cycle N has out_valid=1 and out_imm valid in cycle N+1.
- Simultaneous drain and fill (out_valid && out_ready && an accepted extend): out_imm is replaced with the new result and out_valid stays 1.
- An accepted PREFIX while out_ready drains the buffer: out_valid goes to 0 next cycle.
- While out_valid && !out_ready: out_imm and out_prefixed hold stable and in_ready=0.
- reset asserted mid-operation clears everything immediately. There is no clock dependence.

## Configuration
- IMMSEQ_PREFIX_EN defined: PREFIX mode and the ARMED state are implemented as described.
- Not defined:
  - Mode 10 behaves exactly as SEXT and produces an output.
  - The prefix register and FSM are removed.
  - armed and out_prefixed are tied to 0.

## Test plan
- Reset, then in_imm=13'h1000 with SEXT and out_ready=1 -> one cycle later out_valid=1, out_imm=16'hF000, out_prefixed=0.
- ZEXT with 13'h1000 -> 16'h1000. SHIFT with 13'h0001 -> 16'h0008. SHIFT with 13'h1FFF -> 16'hFFF8.
- PREFIX with in_imm=13'h0005 -> armed=1 and no out_valid. Then SEXT with 13'h0001 -> 16'hA001, out_prefixed=1, armed=0.
- Backpressure: out_ready=0, two back-to-back SEXT requests (13'h0002, 13'h0003) -> the first is held at 16'h0002 with in_ready=0. Raise out_ready -> 16'h0002 drains, then 16'h0003 appears on the next cycle.
- flush asserted with armed=1, out_valid=1 and in_valid=1 -> next cycle out_valid=0, armed=0, and the request is not accepted. Assert reset mid-stream -> all outputs return to 0 immediately.
- Build without IMMSEQ_PREFIX_EN: mode 10 with 13'h1000 -> out_imm=16'hF000 and armed stays 0.
